// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared types and pair-index helpers for the layer compositor
package compositor_pkg;

  localparam logic HS_ACTIVE_DEFAULT = 1'b0;
  localparam logic VS_ACTIVE_DEFAULT = 1'b0;
  localparam int   RGB_CB_DEFAULT    = 4;

  typedef struct packed {
    logic [RGB_CB_DEFAULT-1:0] r;
    logic [RGB_CB_DEFAULT-1:0] g;
    logic [RGB_CB_DEFAULT-1:0] b;
  } rgb_t;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Row-major upper-triangle index of pair (i<j).
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth shift register with a per-bit reset value
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= RST_VAL;
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - fixed-priority layer mixer with frame-synchronous enable/blink and collision flags
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int                    NUM_LAYERS     = 4,
  parameter int                    COLOR_BITS     = 4,
  parameter int                    PIPE_DEPTH     = 2,
  parameter int                    BLINK_DIV_LOG2 = 5,
  parameter logic [3*COLOR_BITS-1:0] BG_COLOR     = '0,
  parameter logic                  HS_ACTIVE      = HS_ACTIVE_DEFAULT,
  parameter logic                  VS_ACTIVE      = VS_ACTIVE_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   hsync_in,
  input  logic                                   vsync_in,
  input  logic                                   display_on_in,
  input  logic [NUM_LAYERS-1:0]                  layer_on,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0]     layer_rgb,
  input  logic [NUM_LAYERS-1:0]                  layer_en_req,
  input  logic [NUM_LAYERS-1:0]                  layer_blink_req,
  output logic [COLOR_BITS-1:0]                  vga_r,
  output logic [COLOR_BITS-1:0]                  vga_g,
  output logic [COLOR_BITS-1:0]                  vga_b,
  output logic                                   vga_hs,
  output logic                                   vga_vs,
  output logic                                   frame_tick,
  output logic [num_pairs(NUM_LAYERS)-1:0]       collision
);

  localparam int RGB_W = 3 * COLOR_BITS;
  localparam int NP    = num_pairs(NUM_LAYERS);
  localparam int FCW   = BLINK_DIV_LOG2 + 1;

  logic                  r_vs_prev;
  logic                  w_fs;
  logic [NUM_LAYERS-1:0] r_en_shadow;
  logic [NUM_LAYERS-1:0] r_blink_shadow;
  logic [FCW-1:0]        r_frame_cnt;
  logic                  w_blink_phase;
  logic [NUM_LAYERS-1:0] w_visible;
  logic [RGB_W-1:0]      w_pix;
  logic [RGB_W-1:0]      r_pipe [PIPE_DEPTH];
  logic [NP-1:0]         w_coll_term;
  logic [NP-1:0]         r_coll_acc;
  logic [NP-1:0]         r_collision;
  logic                  r_frame_tick;
  logic [2:0]            w_sync_out;

  assign w_fs          = (vsync_in == VS_ACTIVE) && (r_vs_prev != VS_ACTIVE);
  assign w_blink_phase = r_frame_cnt[BLINK_DIV_LOG2];
  assign w_visible     = layer_on & r_en_shadow & (~r_blink_shadow | {NUM_LAYERS{~w_blink_phase}});

  // Descending scan so the lowest-index visible layer wins; hidden layers' colour is never selected.
  always_comb begin
    w_pix = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_visible[i]) w_pix = layer_rgb[i*RGB_W +: RGB_W];
    end
  end

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_row
    for (genvar gj = gi + 1; gj < NUM_LAYERS; gj++) begin : g_col
      assign w_coll_term[pair_index(gi, gj, NUM_LAYERS)] =
        display_on_in & layer_on[gi] & layer_on[gj] & r_en_shadow[gi] & r_en_shadow[gj];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_prev      <= VS_ACTIVE;
      r_en_shadow    <= '1;
      r_blink_shadow <= '0;
      r_frame_cnt    <= '0;
      r_coll_acc     <= '0;
      r_collision    <= '0;
      r_frame_tick   <= 1'b0;
    end else begin
      r_vs_prev    <= vsync_in;
      r_frame_tick <= w_fs;
      if (w_fs) begin
        r_en_shadow    <= layer_en_req;
        r_blink_shadow <= layer_blink_req;
        r_frame_cnt    <= r_frame_cnt + FCW'(1);
        r_collision    <= r_coll_acc | w_coll_term;
        r_coll_acc     <= '0;
      end else begin
        r_coll_acc     <= r_coll_acc | w_coll_term;
      end
    end
  end

  // Only stage 0 does work; later stages retime to line up with the sync delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= w_pix;
      for (int k = 1; k < PIPE_DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DEPTH),
    .RST_VAL ({~HS_ACTIVE, ~VS_ACTIVE, 1'b0})
  ) u_sync_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data ({hsync_in, vsync_in, display_on_in}),
    .o_data (w_sync_out)
  );

  assign {vga_r, vga_g, vga_b} = w_sync_out[0] ? r_pipe[PIPE_DEPTH-1] : '0;
  assign vga_hs     = w_sync_out[2];
  assign vga_vs     = w_sync_out[1];
  assign frame_tick = r_frame_tick;
  assign collision  = r_collision;

endmodule
